// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared constants and response-state type for mem_arbiter
package mem_arb_pkg;

    localparam int unsigned DEF_ADDR_W     = 32;
    localparam int unsigned DEF_DATA_W     = 32;
    localparam int unsigned DEF_STARVE_MAX = 4;

    // Bit positions inside the one-hot grant vector
    localparam int unsigned GNT_I = 0;
    localparam int unsigned GNT_D = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RESP_I = 2'd1,
        ST_RESP_D = 2'd2
    } resp_state_e;

endpackage

// File: rtl/mem_arb_prio.sv
// rtl/mem_arb_prio.sv - one-hot grant decision between fetch and data requests
// MEM_ARB_RR_EN: conflicts resolved by last-winner bit instead of starvation count
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX,
    parameter int unsigned CNT_W      = $clog2(STARVE_MAX + 1)
) (
    input  logic             i_req_i,
    input  logic             d_req_i,
`ifdef MEM_ARB_RR_EN
    input  logic             last_d_i,
`else
    input  logic [CNT_W-1:0] starve_cnt_i,
`endif
    output logic [1:0]       gnt_o
);

`ifndef MEM_ARB_RR_EN
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
`endif

    logic fetch_first;

    always_comb begin
`ifdef MEM_ARB_RR_EN
        fetch_first = last_d_i;
`else
        fetch_first = (starve_cnt_i == STARVE_LIM);
`endif
        gnt_o = 2'b00;
        if (i_req_i && d_req_i) begin
            if (fetch_first) begin
                gnt_o[GNT_I] = 1'b1;
            end else begin
                gnt_o[GNT_D] = 1'b1;
            end
        end else if (i_req_i) begin
            gnt_o[GNT_I] = 1'b1;
        end else if (d_req_i) begin
            gnt_o[GNT_D] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data single-port memory arbiter with 1-cycle read response
// MEM_ARB_RR_EN: round-robin conflict resolution replaces the starvation counter
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                m_req,
    output logic                m_we,
    output logic [ADDR_W-3:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_be,
    input  logic [DATA_W-1:0]   m_rdata
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    resp_state_e state_q, state_d;
    logic        i_rvalid_q, d_rvalid_q;
    logic [1:0]  gnt;
    logic [3:0]  unused_addr_bits;

    assign unused_addr_bits = {i_addr[1:0], d_addr[1:0]};

`ifdef MEM_ARB_RR_EN
    logic last_d_q;

    mem_arb_prio #(.STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)) u_prio (
        .i_req_i  (i_req),
        .d_req_i  (d_req),
        .last_d_i (last_d_q),
        .gnt_o    (gnt)
    );

    // Only contested cycles move the winner bit, so conflicts strictly alternate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d_q <= 1'b1;
        end else if (i_req && d_req) begin
            last_d_q <= d_gnt;
        end
    end
`else
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_q;

    mem_arb_prio #(.STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)) u_prio (
        .i_req_i      (i_req),
        .d_req_i      (d_req),
        .starve_cnt_i (starve_q),
        .gnt_o        (gnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else if (i_req && !i_gnt) begin
            if (starve_q != STARVE_LIM) begin
                starve_q <= starve_q + 1'b1;
            end
        end else begin
            starve_q <= '0;
        end
    end
`endif

    // Grants are forced low while reset is held so nothing reaches memory
    assign i_gnt = gnt[GNT_I] & ~rst;
    assign d_gnt = gnt[GNT_D] & ~rst;
    assign m_req = i_gnt | d_gnt;

    always_comb begin
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_be    = '0;
        if (i_gnt) begin
            m_addr = i_addr[ADDR_W-1:2];
            m_be   = '1;
        end else if (d_gnt) begin
            m_we    = d_we;
            m_addr  = d_addr[ADDR_W-1:2];
            m_wdata = d_wdata;
            m_be    = d_be;
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        if (i_gnt) begin
            state_d = ST_RESP_I;
        end else if (d_gnt && !d_we) begin
            state_d = ST_RESP_D;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_rvalid_q <= (state_d == ST_RESP_I);
            d_rvalid_q <= (state_d == ST_RESP_D);
        end
    end

    assign i_rvalid = i_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign i_rdata  = m_rdata;
    assign d_rdata  = m_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter against a rule-level model
module tb_mem_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_req, d_req, d_we;
    logic [31:0]       i_addr, d_addr, d_wdata, m_rdata;
    logic [3:0]        d_be;
    logic              i_gnt, i_rvalid, d_gnt, d_rvalid, m_req, m_we;
    logic [31:0]       i_rdata, d_rdata, m_wdata;
    logic [29:0]       m_addr;
    logic [3:0]        m_be;

    int total = 0;
    int bad   = 0;

    int   s_cnt;
    logic last_d;
    logic exp_irv, exp_drv;
    logic obs_ig, obs_dg;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
        .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One request cycle: drive, check at the falling edge, advance the model, move to the next cycle
    task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                        input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] dbe);
        logic eg, edg;
        i_req = ir; i_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd; d_be = dbe;
        m_rdata = $urandom;
        #4;
        chk("i_rvalid", i_rvalid, exp_irv);
        chk("d_rvalid", d_rvalid, exp_drv);
        if (exp_irv) chk("i_rdata", i_rdata, m_rdata);
        if (exp_drv) chk("d_rdata", d_rdata, m_rdata);
`ifdef MEM_ARB_RR_EN
        eg = ir && (!dr || last_d);
`else
        eg = ir && (!dr || s_cnt == STARVE_MAX);
`endif
        edg = dr && !eg;
        chk("i_gnt", i_gnt, eg);
        chk("d_gnt", d_gnt, edg);
        chk("m_req", m_req, eg | edg);
        if (eg) begin
            chk("m_addr_i", m_addr, ia >> 2);
            chk("m_we_i", m_we, 0);
            chk("m_be_i", m_be, 4'hF);
        end else if (edg) begin
            chk("m_addr_d", m_addr, da >> 2);
            chk("m_we_d", m_we, dwe);
            chk("m_be_d", m_be, dbe);
            if (dwe) chk("m_wdata", m_wdata, dwd);
        end
        obs_ig = i_gnt;
        obs_dg = d_gnt;
`ifdef MEM_ARB_RR_EN
        if (ir && dr) last_d = edg;
`else
        if (ir && !eg) s_cnt = (s_cnt < STARVE_MAX) ? s_cnt + 1 : STARVE_MAX;
        else s_cnt = 0;
`endif
        exp_irv = eg;
        exp_drv = edg && !dwe;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        s_cnt = 0; last_d = 1'b1; exp_irv = 1'b0; exp_drv = 1'b0;
    endtask

    task automatic idle();
        step(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0);
    endtask

    logic [1:0] seq_exp [6];
    logic        ri, rd, rwe;
    logic [31:0] ra, rda, rwd;
    logic [3:0]  rbe;

    initial begin
        rst = 1'b1;
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        i_addr = 32'h100; d_addr = 32'h2000; d_wdata = '0; d_be = 4'hF; m_rdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #5;
        chk("rst_i_gnt", i_gnt, 0);
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_m_req", m_req, 0);
        chk("rst_i_rvalid", i_rvalid, 0);
        chk("rst_d_rvalid", d_rvalid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Both held: starvation order or alternating order, depending on build
`ifdef MEM_ARB_RR_EN
        seq_exp = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`else
        seq_exp = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
`endif
        for (int k = 0; k < 6; k++) begin
            step(1, 32'h100, 1, 0, 32'h2000, 32'h0, 4'hF);
            chk($sformatf("seq%0d", k), {obs_dg, obs_ig}, seq_exp[k]);
        end
        idle();
        idle();

        step(1, 32'h100, 0, 0, 32'h0, 32'h0, 4'h0);
        chk("fetch_m_addr", obs_ig, 1);
        idle();

        step(1, 32'h100, 1, 0, 32'h2000, 32'h0, 4'hF);
        idle();

        step(0, 32'h0, 1, 1, 32'h44, 32'hDEADBEEF, 4'b0011);
        idle();

        // Reset while a fetch response is due: response must vanish
        step(1, 32'h100, 0, 0, 32'h0, 32'h0, 4'h0);
        chk("pre_rst_i_rvalid", i_rvalid, 1);
        rst = 1'b1;
        #1;
        chk("rst_drop_i_rvalid", i_rvalid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        idle();
        idle();

        ri = 0; rd = 0; rwe = 0; ra = 0; rda = 0; rwd = 0; rbe = 0;
        for (int n = 0; n < 300; n++) begin
            if (!ri || obs_ig) begin
                ri = ($urandom_range(0, 9) < 7);
                ra = $urandom;
            end
            if (!rd || obs_dg) begin
                rd  = ($urandom_range(0, 9) < 7);
                rwe = $urandom_range(0, 1);
                rda = $urandom;
                rwd = $urandom;
                rbe = 4'($urandom);
            end
            step(ri, ra, rd, rwe, rda, rwd, rbe);
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
